// File: rtl/irigb_event_stamper.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// irigb_event_stamper
//
// Keeps a local {seconds, nanoseconds} clock that is disciplined by the
// recovered IRIG-B time word and the recovered PPS line. Rising edges on an
// asynchronous event input are timestamped against this clock, corrected for
// the synchroniser delay, and queued in a first-word-fall-through FIFO.
//
// Ports
//   sclk         system clock
//   rst          synchronous reset, active high
//   time_in      recovered time {sec[63:32], ns[31:0]}
//   pps_in       recovered PPS (asynchronous)
//   evt_in       external event line (asynchronous)
//   stamp_data   head stamp {sec, ns}, registered
//   stamp_valid  queue not empty
//   stamp_ready  consumer accepts the head stamp
//   stamp_ovf    sticky flag: an event was dropped on a full queue
//   ovf_clr      clears stamp_ovf (a same-cycle drop wins)
//   cur_time     local time {sec, ns}
//   time_locked  local time is valid
// ---------------------------------------------------------------------------
module irigb_event_stamper #(
    parameter int CLK_PERIOD_NS = 20,
    parameter int SYNC_STAGES   = 2,
    parameter int FIFO_AW       = 4,
    parameter int HOLDOVER_S    = 3
) (
    input  logic        sclk,
    input  logic        rst,
    input  logic [63:0] time_in,
    input  logic        pps_in,
    input  logic        evt_in,
    output logic [63:0] stamp_data,
    output logic        stamp_valid,
    input  logic        stamp_ready,
    output logic        stamp_ovf,
    input  logic        ovf_clr,
    output logic [63:0] cur_time,
    output logic        time_locked
);

    localparam logic [31:0] NS_PER_S = 32'd1_000_000_000;
    localparam logic [31:0] NS_HALF  = 32'd500_000_000;
    localparam logic [31:0] NS_INC   = 32'(CLK_PERIOD_NS);
    // Delay from the event pin to the detection cycle, backed out of each stamp
    localparam logic [31:0] NS_COMP  = 32'(SYNC_STAGES * CLK_PERIOD_NS);
    localparam int          DEPTH    = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] FIFO_FULL = (FIFO_AW + 1)'(DEPTH);
    localparam int          HW       = (HOLDOVER_S < 1) ? 1 : $clog2(HOLDOVER_S + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLDOVER_S);

    // Registered state
    logic [63:0]            time_q, time_d;
    logic [31:0]            sec_q, sec_d;
    logic [31:0]            ns_q, ns_d;
    logic                   locked_q, locked_d;
    logic [HW-1:0]          hold_q, hold_d;
    logic [SYNC_STAGES-1:0] pps_sync_q, pps_sync_d;
    logic                   pps_prev_q, pps_prev_d;
    logic [SYNC_STAGES-1:0] evt_sync_q, evt_sync_d;
    logic                   evt_prev_q, evt_prev_d;
    logic [FIFO_AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]       count_q, count_d;
    logic                   valid_q, valid_d;
    logic [63:0]            head_q, head_d;
    logic                   ovf_q, ovf_d;
    logic [63:0]            mem_q [DEPTH];

    // Combinational helpers
    logic        load_s;
    logic        pps_rise_s;
    logic        evt_rise_s;
    logic [31:0] ns_inc_s;
    logic [63:0] stamp_s;
    logic        full_s;
    logic        pop_s;
    logic        push_req_s;
    logic        push_s;
    logic        drop_s;

    // Synchronisers, edge detectors and the load comparison
    always_comb begin
        time_d     = time_in;
        pps_sync_d = {pps_sync_q[SYNC_STAGES-2:0], pps_in};
        evt_sync_d = {evt_sync_q[SYNC_STAGES-2:0], evt_in};
        pps_prev_d = pps_sync_q[SYNC_STAGES-1];
        evt_prev_d = evt_sync_q[SYNC_STAGES-1];
        pps_rise_s = pps_sync_q[SYNC_STAGES-1] & ~pps_prev_q;
        evt_rise_s = evt_sync_q[SYNC_STAGES-1] & ~evt_prev_q;
        load_s     = (time_in != time_q);
        ns_inc_s   = ns_q + NS_INC;
    end

    // Local time counter: load beats PPS beats free-running increment
    always_comb begin
        sec_d    = sec_q;
        ns_d     = ns_q;
        locked_d = locked_q;
        hold_d   = hold_q;
        if (load_s) begin
            sec_d    = time_in[63:32];
            ns_d     = time_in[31:0];
            locked_d = 1'b1;
            hold_d   = {HW{1'b0}};
        end else if (pps_rise_s) begin
            // PPS near the end of a second means our second is about to turn
            if (ns_q >= NS_HALF) begin
                sec_d = sec_q + 32'd1;
            end else begin
                sec_d = sec_q;
            end
            ns_d = 32'd0;
        end else if (ns_inc_s >= NS_PER_S) begin
            ns_d  = ns_inc_s - NS_PER_S;
            sec_d = sec_q + 32'd1;
            // Unassisted rollovers count toward losing lock; count saturates
            if (hold_q != HOLD_MAX) begin
                hold_d = hold_q + HW'(1);
            end else begin
                hold_d = hold_q;
            end
            if (hold_d == HOLD_MAX) begin
                locked_d = 1'b0;
            end else begin
                locked_d = locked_q;
            end
        end else begin
            ns_d = ns_inc_s;
        end
    end

    // Event stamp, corrected for synchroniser latency with a borrow across seconds
    always_comb begin
        if (ns_q >= NS_COMP) begin
            stamp_s = {sec_q, ns_q - NS_COMP};
        end else begin
            stamp_s = {sec_q - 32'd1, ns_q + NS_PER_S - NS_COMP};
        end
    end

    // Queue control: push/pop decisions, pointers, occupancy and overflow flag
    always_comb begin
        full_s     = (count_q == FIFO_FULL);
        pop_s      = valid_q & stamp_ready;
        push_req_s = evt_rise_s & locked_q;
        push_s     = push_req_s & (~full_s | pop_s);
        drop_s     = push_req_s & full_s & ~pop_s;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
            2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
            default: count_d = count_q;
        endcase
        valid_d = (count_d != (FIFO_AW + 1)'(0));

        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Registered head: bypass the incoming stamp when it lands in the head slot
    always_comb begin
        if (count_d == (FIFO_AW + 1)'(0)) begin
            head_d = 64'd0;
        end else if (push_s && (rd_ptr_d == wr_ptr_q)) begin
            head_d = stamp_s;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    // Stamp storage; contents need no reset because the pointers define validity
    always_ff @(posedge sclk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= stamp_s;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge sclk) begin
        if (rst) begin
            time_q     <= 64'd0;
            sec_q      <= 32'd0;
            ns_q       <= 32'd0;
            locked_q   <= 1'b0;
            hold_q     <= {HW{1'b0}};
            pps_sync_q <= {SYNC_STAGES{1'b0}};
            pps_prev_q <= 1'b0;
            evt_sync_q <= {SYNC_STAGES{1'b0}};
            evt_prev_q <= 1'b0;
            wr_ptr_q   <= {FIFO_AW{1'b0}};
            rd_ptr_q   <= {FIFO_AW{1'b0}};
            count_q    <= {(FIFO_AW + 1){1'b0}};
            valid_q    <= 1'b0;
            head_q     <= 64'd0;
            ovf_q      <= 1'b0;
        end else begin
            time_q     <= time_d;
            sec_q      <= sec_d;
            ns_q       <= ns_d;
            locked_q   <= locked_d;
            hold_q     <= hold_d;
            pps_sync_q <= pps_sync_d;
            pps_prev_q <= pps_prev_d;
            evt_sync_q <= evt_sync_d;
            evt_prev_q <= evt_prev_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            head_q     <= head_d;
            ovf_q      <= ovf_d;
        end
    end

    assign stamp_data  = head_q;
    assign stamp_valid = valid_q;
    assign stamp_ovf   = ovf_q;
    assign cur_time    = {sec_q, ns_q};
    assign time_locked = locked_q;

endmodule

// File: tb/tb_irigb_event_stamper.sv
`timescale 1ns/1ps
// Directed bench for irigb_event_stamper. A second instance with a very
// long clock period makes local-second rollovers frequent enough to reach
// the holdover limit.
module tb_irigb_event_stamper;

    logic        sclk = 1'b0;
    logic        rst;
    logic [63:0] time_in;
    logic        pps_in;
    logic        evt_in;
    logic [63:0] stamp_data;
    logic        stamp_valid;
    logic        stamp_ready;
    logic        stamp_ovf;
    logic        ovf_clr;
    logic [63:0] cur_time;
    logic        time_locked;

    logic [63:0] h_time_in;
    logic        h_evt_in;
    logic [63:0] h_stamp_data;
    logic        h_stamp_valid;
    logic        h_stamp_ready;
    logic        h_stamp_ovf;
    logic [63:0] h_cur_time;
    logic        h_time_locked;

    int n_cmp = 0;
    int n_err = 0;

    always #10 sclk = ~sclk;

    irigb_event_stamper u_dut (
        .sclk(sclk), .rst(rst), .time_in(time_in), .pps_in(pps_in),
        .evt_in(evt_in), .stamp_data(stamp_data), .stamp_valid(stamp_valid),
        .stamp_ready(stamp_ready), .stamp_ovf(stamp_ovf), .ovf_clr(ovf_clr),
        .cur_time(cur_time), .time_locked(time_locked)
    );

    irigb_event_stamper #(.CLK_PERIOD_NS(250_000_000)) u_hold (
        .sclk(sclk), .rst(rst), .time_in(h_time_in), .pps_in(pps_in),
        .evt_in(h_evt_in), .stamp_data(h_stamp_data), .stamp_valid(h_stamp_valid),
        .stamp_ready(h_stamp_ready), .stamp_ovf(h_stamp_ovf), .ovf_clr(ovf_clr),
        .cur_time(h_cur_time), .time_locked(h_time_locked)
    );

    function automatic logic [63:0] tm(input logic [31:0] s, input logic [31:0] n);
        return {s, n};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d:%0d expected %0d:%0d", tag,
                     got[63:32], got[31:0], exp[63:32], exp[31:0]);
        end
    endtask

    // Advance n rising edges and settle 1 ns past the last one
    task automatic step(input int n);
        repeat (n) @(posedge sclk);
        #1;
    endtask

    initial begin
        logic [63:0] exp;
        rst = 1'b1; time_in = 64'd0; pps_in = 1'b0; evt_in = 1'b0;
        stamp_ready = 1'b0; ovf_clr = 1'b0;
        h_time_in = 64'd0; h_evt_in = 1'b0; h_stamp_ready = 1'b0;
        step(3);
        check_eq("rst_cur", cur_time, 64'd0);
        check_eq("rst_valid", {63'd0, stamp_valid}, 64'd0);
        check_eq("rst_data", stamp_data, 64'd0);
        check_eq("rst_ovf", {63'd0, stamp_ovf}, 64'd0);
        check_eq("rst_lock", {63'd0, time_locked}, 64'd0);
        rst = 1'b0;

        // Load then roll over the second
        time_in = tm(32'd100, 32'd999_999_980);
        step(1);
        check_eq("load", cur_time, tm(32'd100, 32'd999_999_980));
        check_eq("load_lock", {63'd0, time_locked}, 64'd1);
        step(1);
        check_eq("roll", cur_time, tm(32'd101, 32'd0));
        step(1);
        check_eq("incr", cur_time, tm(32'd101, 32'd20));

        // Event detected at {101,1000}
        time_in = tm(32'd101, 32'd0);
        step(1);
        step(48);
        evt_in = 1'b1;
        step(2);
        check_eq("evt_cur", cur_time, tm(32'd101, 32'd1000));
        evt_in = 1'b0;
        step(1);
        check_eq("evt_valid", {63'd0, stamp_valid}, 64'd1);
        check_eq("evt_stamp", stamp_data, tm(32'd101, 32'd960));
        stamp_ready = 1'b1;
        step(1);
        stamp_ready = 1'b0;
        check_eq("evt_pop", {63'd0, stamp_valid}, 64'd0);

        // Event detected at {101,20}: borrow into previous second
        evt_in = 1'b1;
        step(1);
        time_in = tm(32'd101, 32'd20);
        step(1);
        evt_in = 1'b0;
        step(1);
        check_eq("borrow", stamp_data, tm(32'd100, 32'd999_999_980));
        stamp_ready = 1'b1;
        step(1);
        stamp_ready = 1'b0;
        check_eq("borrow_pop", {63'd0, stamp_valid}, 64'd0);

        // PPS late in the second rounds up
        pps_in = 1'b1;
        step(1);
        time_in = tm(32'd5, 32'd999_999_900);
        step(1);
        step(1);
        check_eq("pps_up", cur_time, tm(32'd6, 32'd0));
        pps_in = 1'b0;
        step(3);

        // PPS early in the second keeps the second
        pps_in = 1'b1;
        step(1);
        time_in = tm(32'd6, 32'd100);
        step(1);
        step(1);
        check_eq("pps_keep", cur_time, tm(32'd6, 32'd0));
        pps_in = 1'b0;
        step(3);

        // PPS and load in the same cycle: load wins
        pps_in = 1'b1;
        step(2);
        time_in = tm(32'd7, 32'd5000);
        step(1);
        check_eq("pps_load", cur_time, tm(32'd7, 32'd5000));
        pps_in = 1'b0;
        step(1);
        check_eq("pps_load_inc", cur_time, tm(32'd7, 32'd5020));
        step(2);

        // Fill the queue: 16 events 10 cycles apart, stamps {200, 200*i}
        time_in = tm(32'd200, 32'd0);
        step(1);
        for (int i = 0; i < 16; i++) begin
            evt_in = 1'b1;
            step(1);
            evt_in = 1'b0;
            step(9);
        end
        check_eq("full_no_ovf", {63'd0, stamp_ovf}, 64'd0);
        evt_in = 1'b1;
        step(1);
        evt_in = 1'b0;
        step(9);
        check_eq("ovf_set", {63'd0, stamp_ovf}, 64'd1);
        check_eq("ovf_head", stamp_data, tm(32'd200, 32'd0));
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        check_eq("ovf_clr", {63'd0, stamp_ovf}, 64'd0);

        // Full queue, push and pop on the same edge: nothing dropped
        evt_in = 1'b1;
        step(2);
        evt_in = 1'b0;
        stamp_ready = 1'b1;
        step(1);
        stamp_ready = 1'b0;
        check_eq("fullpp_ovf", {63'd0, stamp_ovf}, 64'd0);
        check_eq("fullpp_head", stamp_data, tm(32'd200, 32'd200));

        // Drain 15 in order
        stamp_ready = 1'b1;
        for (int j = 0; j < 15; j++) begin
            exp = tm(32'd200, 32'(200 * (j + 1)));
            check_eq("drain", stamp_data, exp);
            step(1);
        end
        stamp_ready = 1'b0;
        check_eq("last_valid", {63'd0, stamp_valid}, 64'd1);
        check_eq("last_stamp", stamp_data, tm(32'd200, 32'd3420));

        // Holdover on the long-period instance: rollovers every 4 cycles
        h_time_in = tm(32'd1000, 32'd0);
        step(1);
        check_eq("h_load", h_cur_time, tm(32'd1000, 32'd0));
        check_eq("h_lock", {63'd0, h_time_locked}, 64'd1);
        step(11);
        check_eq("h_pre", h_cur_time, tm(32'd1002, 32'd750_000_000));
        check_eq("h_pre_lock", {63'd0, h_time_locked}, 64'd1);
        step(1);
        check_eq("h_roll3", h_cur_time, tm(32'd1003, 32'd0));
        check_eq("h_unlock", {63'd0, h_time_locked}, 64'd0);
        h_evt_in = 1'b1;
        step(1);
        h_evt_in = 1'b0;
        step(4);
        check_eq("h_no_stamp", {63'd0, h_stamp_valid}, 64'd0);
        check_eq("h_no_ovf", {63'd0, h_stamp_ovf}, 64'd0);

        // Reset while a stamp is still queued
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_eq("rst2_valid", {63'd0, stamp_valid}, 64'd0);
        check_eq("rst2_cur", cur_time, 64'd0);
        check_eq("rst2_data", stamp_data, 64'd0);
        check_eq("rst2_lock", {63'd0, time_locked}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/irigb_event_stamper.md
Name: irigb_event_stamper

Overview:
- Sits downstream of the IRIG-B time recovery stage. It consumes the recovered 64-bit time word and the PPS line in the sclk domain.
- It keeps a free-running local nanosecond/second counter disciplined by both inputs.
- It timestamps rising edges on an asynchronous event line and buffers the stamps in a first-word-fall-through queue.
- Software and DMA logic drain the queue through a valid/ready interface.

Parameters:
CLK_PERIOD_NS, 20, sclk period in ns; local counter increment per cycle
SYNC_STAGES, 2, flip-flops in the evt_in and pps_in synchronisers (>=2)
FIFO_AW, 4, stamp queue address width; depth = 2**FIFO_AW
HOLDOVER_S, 3, local second rollovers without a time load before lock is dropped

Ports:
sclk  in  1  system clock
rst  in  1  synchronous reset, active high
time_in  in  64  recovered time, [63:32] seconds, [31:0] nanoseconds (0..999_999_999)
pps_in  in  1  recovered PPS, asynchronous
evt_in  in  1  external event line, asynchronous
stamp_data  out  64  head stamp, {sec, ns}
stamp_valid  out  1  queue not empty
stamp_ready  in  1  consumer accepts head
stamp_ovf  out  1  sticky: event dropped because queue full
ovf_clr  in  1  clears stamp_ovf
cur_time  out  64  local time {sec, ns}
time_locked  out  1  local time valid

Behaviour:
- Reset (sync, rst=1 at an sclk edge):
  - All outputs 0; queue emptied; time_q, counters, synchronisers, holdover count 0.
  - Reset mid-operation discards all queued stamps.
- Local counter (ns, sec); cur_time = {sec, ns}, registered. Per-cycle priority:
  1. Load: time_in != time_q (time_q is time_in registered every cycle). Next cycle {sec, ns} = time_in verbatim. time_locked <= 1; holdover count <= 0.
  2. PPS: rising edge of synchronised pps_in (edge detected SYNC_STAGES+1 edges after the input changes). If ns >= 500_000_000, sec <= sec+1; else sec unchanged. ns <= 0.
  3. Increment:
     - If ns + CLK_PERIOD_NS >= 1_000_000_000: ns <= ns + CLK_PERIOD_NS - 1_000_000_000, sec <= sec+1, and this counts as a rollover.
     - Otherwise ns <= ns + CLK_PERIOD_NS.
  - sec wraps modulo 2^32. Nanosecond arithmetic uses 32-bit unsigned; ns never reaches 1e9.
- Constant time_in == 0 after reset never loads. This is accepted.
- Holdover:
  - Every increment rollover with no load in the same cycle increments the holdover count.
  - A PPS-driven second step is not a rollover.
  - When the count reaches HOLDOVER_S, time_locked <= 0 in the same edge. The count saturates.
- Event capture:
  - evt_in passes through the SYNC_STAGES synchroniser plus one edge register.
  - A rising edge is "detected" in cycle d, using cur_time as registered at d (pre-update value).
  - Compensation C = SYNC_STAGES*CLK_PERIOD_NS.
  - If ns >= C: stamp = {sec, ns-C}. Else: stamp = {sec-1, ns + 1_000_000_000 - C}.
  - Stamp is pushed at the end of cycle d only if time_locked=1. Otherwise the event is silently dropped and stamp_ovf is not set.
- Queue (first-word-fall-through):
  - stamp_valid = not empty; stamp_data stable while stamp_valid=1 and stamp_ready=0.
  - Pop on stamp_valid & stamp_ready.
  - First push into an empty queue: stamp_valid=1 the following cycle.
  - Push when full:
    - If a pop occurs in the same cycle, both happen and the count is unchanged.
    - Otherwise the stamp is dropped and stamp_ovf <= 1.
  - Simultaneous push and pop when not full: count unchanged, order preserved.
  - Empty queue with stamp_ready=1: no effect.
- stamp_ovf: cleared by ovf_clr. If ovf_clr and a new drop occur in the same cycle, set wins.
- Event edges closer than one cycle apart after synchronisation merge. At most one stamp per cycle.

Test Plan:
- Load (CLK_PERIOD_NS=20): time_in <= {100, 999_999_980}
  -> cur_time {100,999_999_980} one cycle after the load cycle, then {101,0}, then {101,20}; time_locked=1.
- Event: locked, evt_in rises so detection occurs with cur_time={101,1000}
  -> stamp {101,960}, stamp_valid=1 next cycle; popped with stamp_ready=1.
- Event at {101,20} (borrow) -> stamp {100,999_999_980}.
- PPS rounding:
  - ns=999_999_900, sec=5 -> {6,0}.
  - ns=100, sec=6 -> {6,0}.
  - PPS in the same cycle as a load -> the load value wins.
- Overflow: stamp_ready=0, 17 events spaced 10 cycles
  -> 16 stored, stamp_ovf=1.
  -> ovf_clr pulse clears it.
  -> Draining returns the 16 stamps in order, increasing by 200 ns.
  - Also: full plus simultaneous pop and push -> no drop.
- Holdover and reset:
  - time_in constant for 3 rollovers -> time_locked=0 at the 3rd rollover edge; a subsequent event produces no stamp.
  - rst mid-drain -> stamp_valid=0, cur_time=0 the next cycle.
